mips_regfile_sb: RTL

- 32 x 32-bit MIPS general-purpose register file and the consumer of the 5-bit destination-register select produced in decode (rt/rd choice).
- Provides two asynchronous read ports (rs, rt) and one synchronous write-back port.
- Includes a pending-write scoreboard for load destinations, which raises a stall when decode reads a register whose load result has not yet been written back.
- Sits between decode (read and issue) and write-back (write).

---
 rtl/mips_regfile_sb_if.sv | 28 ++
 rtl/mips_regfile_sb.sv | 96 +++++++++
 2 files changed

// File: rtl/mips_regfile_sb_if.sv
// Decode/write-back bundle for the MIPS register file and its load scoreboard.
// The master side drives addresses, write-back and issue; the slave returns read data and stall.
interface mips_regfile_sb_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0]      RA1;
   logic [ADDR_W-1:0]      RA2;
   logic [DATA_W-1:0]      RD1;
   logic [DATA_W-1:0]      RD2;
   logic                   WE;
   logic [ADDR_W-1:0]      WA;
   logic [DATA_W-1:0]      WD;
   logic                   ISSUE;
   logic [ADDR_W-1:0]      IA;
   logic                   STALL;
   logic [2**ADDR_W-1:0]   PEND;

   modport master (
      output RA1, RA2, WE, WA, WD, ISSUE, IA,
      input  RD1, RD2, STALL, PEND
   );

   modport slave (
      input  RA1, RA2, WE, WA, WD, ISSUE, IA,
      output RD1, RD2, STALL, PEND
   );
endinterface

// File: rtl/mips_regfile_sb.sv
// 32x32 register file (2 async reads, 1 sync write) with a pending-load scoreboard driving STALL.
// Reads/STALL are zero-latency; never backpressures write-back. REGFILE_BYPASS_EN adds write-through.
module mips_regfile_sb #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input  logic            clk,
   input  logic            rst,
   mips_regfile_sb_if.slave bus
);
   localparam int DEPTH = 2**ADDR_W;

   logic [DATA_W-1:0] r_regs [DEPTH];
   logic [DEPTH-1:0]  r_pend;

   logic              w_wr_en;
   logic [DEPTH-1:0]  w_set;
   logic [DEPTH-1:0]  w_clr;
   logic [DEPTH-1:0]  w_pend_vis;
   logic [DATA_W-1:0] w_rd1;
   logic [DATA_W-1:0] w_rd2;
   logic              w_stall;

   // Register 0 is hardwired: never written, never marked pending.
   assign w_wr_en = bus.WE && (bus.WA != '0);

   always_comb begin
      w_set = '0;
      w_clr = '0;
      if (bus.ISSUE && (bus.IA != '0)) begin
         w_set[bus.IA] = 1'b1;
      end
      if (bus.WE) begin
         w_clr[bus.WA] = 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_regs[i] <= '0;
         end
      end else if (w_wr_en) begin
         r_regs[bus.WA] <= bus.WD;
      end
   end

   // Set is applied after clear so a re-issue in the retiring cycle keeps the register pending.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_pend <= '0;
      end else begin
         r_pend <= (r_pend & ~w_clr) | w_set;
      end
   end

`ifdef REGFILE_BYPASS_EN
   logic [DEPTH-1:0] w_wr_hit;

   always_comb begin
      w_wr_hit = '0;
      if (w_wr_en) begin
         w_wr_hit[bus.WA] = 1'b1;
      end
   end

   // A register retiring this cycle is readable now, unless the same cycle re-issues it.
   assign w_pend_vis = r_pend & ~(w_wr_hit & ~w_set);

   always_comb begin
      w_rd1 = (bus.RA1 == '0) ? '0 : r_regs[bus.RA1];
      w_rd2 = (bus.RA2 == '0) ? '0 : r_regs[bus.RA2];
      if (w_wr_en && (bus.WA == bus.RA1)) begin
         w_rd1 = bus.WD;
      end
      if (w_wr_en && (bus.WA == bus.RA2)) begin
         w_rd2 = bus.WD;
      end
   end
`else
   assign w_pend_vis = r_pend;

   always_comb begin
      w_rd1 = (bus.RA1 == '0) ? '0 : r_regs[bus.RA1];
      w_rd2 = (bus.RA2 == '0) ? '0 : r_regs[bus.RA2];
   end
`endif

   assign w_stall = ((bus.RA1 != '0) && w_pend_vis[bus.RA1]) ||
                    ((bus.RA2 != '0) && w_pend_vis[bus.RA2]);

   assign bus.RD1   = w_rd1;
   assign bus.RD2   = w_rd2;
   assign bus.STALL = w_stall;
   assign bus.PEND  = r_pend;
endmodule
